// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared FSM states, pattern modes and pattern generator for the RAM exerciser
package ram_bist_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  localparam logic [1:0] MODE_INC = 2'd0;
  localparam logic [1:0] MODE_INV = 2'd1;
  localparam logic [1:0] MODE_CHK = 2'd2;
  localparam logic [1:0] MODE_ONES = 2'd3;
  localparam int PAT_W = 64;
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr, input logic [1:0] mode);
    return mode == MODE_INC ? addr :
           mode == MODE_INV ? ~addr :
           mode == MODE_CHK ? (addr[0] ? {32{2'b10}} : {32{2'b01}}) : {PAT_W{1'b1}};
  endfunction
endpackage

// File: rtl/ram_sp.sv
// ram_sp: inferred single-port RAM with a registered one-cycle read
module ram_sp #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [DEPTH];
  // write on we, otherwise register the addressed word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else dout <= mem[addr];
    end
  end
endmodule

// File: rtl/ram_sp_bist.sv
// ram_sp_bist: writes a pattern to every RAM word, reads it back and reports mismatches
module ram_sp_bist import ram_bist_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W = ADDR_W + 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, inj_addr_q, exp_addr;
  logic [1:0] mode_q;
  logic inj_q, cmp_valid, last, mismatch;
  logic [DATA_W-1:0] wdata, rdata, exp_data;
  assign last = addr == ADDR_W'(DEPTH - 1);
  assign busy = state inside {WRITE, READ, DRAIN};
  assign done = state == DONE;
  assign wdata = DATA_W'(pattern(PAT_W'(addr), mode_q)) ^ DATA_W'(inj_q && addr == inj_addr_q);
  assign exp_data = DATA_W'(pattern(PAT_W'(exp_addr), mode_q));
  assign mismatch = cmp_valid && rdata != exp_data;
  ram_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(sys_clk),
    .en(state == WRITE || state == READ),
    .we(state == WRITE),
    .addr(addr),
    .din(wdata),
    .dout(rdata)
  );
  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else state <= state_n;
  end
  // sequencing: write sweep, read sweep, one drain cycle for the last read, then done
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? WRITE : IDLE;
      WRITE:   state_n = last ? READ : WRITE;
      READ:    state_n = last ? DRAIN : READ;
      DRAIN:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // address sweep, latched test setup, read-aligned compare and error capture
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr <= '0;
      mode_q <= '0;
      inj_q <= 1'b0;
      inj_addr_q <= '0;
      exp_addr <= '0;
      cmp_valid <= 1'b0;
      err_cnt <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass <= 1'b0;
    end else begin
      addr <= (state == WRITE || state == READ) && !last ? addr + ADDR_W'(1) : '0;
      cmp_valid <= state == READ;
      exp_addr <= addr;
      if (state == IDLE && start) begin
        mode_q <= mode;
        inj_q <= inj_en;
        inj_addr_q <= inj_addr;
        err_cnt <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
        pass <= 1'b0;
      end
      if (mismatch) begin
        err_cnt <= &err_cnt ? err_cnt : err_cnt + CNT_W'(1);
        if (err_cnt == '0) begin
          first_err_addr <= exp_addr;
          first_err_data <= rdata;
        end
      end
      if (state == DRAIN) pass <= err_cnt == '0 && !mismatch;
    end
  end
endmodule

// File: tb/tb_ram_sp_bist.sv
// tb_ram_sp_bist: directed tests of ram_sp_bist against a per-cycle reference model
module tb_ram_sp_bist;
  localparam int DA = 32, WA = 8, AA = 5, CA = 6;
  localparam int DB = 20, WB = 4, AB = 5, CB = 6;
  typedef struct packed {logic [31:0] err; logic [31:0] fa; logic [63:0] fd;} res_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic start_a = 0, inj_a = 0, start_b = 0, inj_b = 0;
  logic [1:0] mode_a = 0, mode_b = 0;
  logic [AA-1:0] ia_a = 0;
  logic [AB-1:0] ia_b = 0;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [CA-1:0] err_a;
  logic [CB-1:0] err_b;
  logic [AA-1:0] fa_a;
  logic [AB-1:0] fa_b;
  logic [WA-1:0] fd_a;
  logic [WB-1:0] fd_b;
  ram_sp_bist dut_a (
    .sys_clk(clk), .sys_rst(rst), .start(start_a), .mode(mode_a), .inj_en(inj_a), .inj_addr(ia_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .first_err_addr(fa_a), .first_err_data(fd_a)
  );
  ram_sp_bist #(.DATA_W(WB), .DEPTH(DB)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .start(start_b), .mode(mode_b), .inj_en(inj_b), .inj_addr(ia_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .first_err_addr(fa_b), .first_err_data(fd_b)
  );
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] pat(input int a, input logic [1:0] m, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case (m)
      2'd0: return 64'(a) & mask;
      2'd1: return ~64'(a) & mask;
      2'd2: return (a % 2 == 1 ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555) & mask;
      default: return mask;
    endcase
  endfunction
  function automatic res_t predict(input logic [1:0] m, input logic inj, input int ia, input int d, input int w);
    res_t r;
    logic [63:0] wd;
    r = '0;
    for (int a = 0; a < d; a++) begin
      wd = pat(a, m, w) ^ 64'(inj && a == ia);
      if (wd != pat(a, m, w)) begin
        if (r.err == 0) begin
          r.fa = 32'(a);
          r.fd = wd;
        end
        r.err = r.err + 32'd1;
      end
    end
    return r;
  endfunction
  logic m_act = 0, m_have = 0, m_inj = 0;
  int m_c = 0, m_ia = 0;
  logic [1:0] m_mode = 0;
  res_t m_res = '0;
  // reference for instance A: cycle count since the accepted start, results published at done
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 0;
      m_c <= 0;
      m_have <= 0;
      m_res <= '0;
    end else if (m_act) begin
      m_act <= m_c != 2 * DA + 2;
      m_c <= m_c + 1;
      if (m_c == 2 * DA + 1) begin
        m_have <= 1;
        m_res <= predict(m_mode, m_inj, m_ia, DA, WA);
      end
    end else if (start_a) begin
      m_act <= 1;
      m_c <= 1;
      m_have <= 0;
      m_res <= '0;
      m_mode <= mode_a;
      m_inj <= inj_a;
      m_ia <= int'(ia_a);
    end
  end
  // compare instance A against the reference every cycle
  always @(negedge clk) begin
    chk("busy_a", busy_a, m_act && m_c <= 2 * DA + 1);
    chk("done_a", done_a, m_act && m_c == 2 * DA + 2);
    chk("pass_a", pass_a, m_have && m_res.err == 0);
    if (!(m_act && m_c <= 2 * DA + 1)) begin
      chk("err_cnt_a", err_a, m_res.err);
      chk("first_addr_a", fa_a, m_res.fa);
      chk("first_data_a", fd_a, m_res.fd);
    end
  end
  task automatic run(input bit b, input logic [1:0] m, input logic inj, input int ia, output int n_done, output int n_busy);
    if (b) begin
      mode_b = m; inj_b = inj; ia_b = AB'(ia); start_b = 1;
    end else begin
      mode_a = m; inj_a = inj; ia_a = AA'(ia); start_a = 1;
    end
    @(posedge clk); #1;
    start_a = 0;
    start_b = 0;
    n_done = 0;
    n_busy = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (b ? busy_b : busy_a) n_busy++;
      if (b ? done_b : done_a) begin
        n_done = n;
        break;
      end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    int nd, nb, cnt, d1, d2;
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst pass", pass_a, 0);
    chk("rst err", err_a, 0);
    chk("rst fa", fa_a, 0);
    chk("rst fd", fd_a, 0);
    rst = 0;
    @(posedge clk); #1;
    run(0, 2'd0, 0, 0, nd, nb);
    chk("t1 done cycle", nd, 66);
    chk("t1 busy cycles", nb, 65);
    chk("t1 pass", pass_a, 1);
    chk("t1 err", err_a, 0);
    run(0, 2'd2, 1, 5, nd, nb);
    chk("t2 pass", pass_a, 0);
    chk("t2 err", err_a, 1);
    chk("t2 fa", fa_a, 5);
    chk("t2 fd", fd_a, 8'hAB);
    run(0, 2'd1, 1, 31, nd, nb);
    chk("t3 done cycle", nd, 66);
    chk("t3 err", err_a, 1);
    chk("t3 fa", fa_a, 31);
    chk("t3 fd", fd_a, 8'hE1);
    mode_a = 0; inj_a = 1; ia_a = 2; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    repeat (39) @(posedge clk);
    #2;
    chk("pre-rst busy", busy_a, 1);
    #1 rst = 1;
    #1;
    chk("async rst busy", busy_a, 0);
    chk("async rst done", done_a, 0);
    chk("async rst pass", pass_a, 0);
    chk("async rst err", err_a, 0);
    @(posedge clk); #1;
    rst = 0;
    run(0, 2'd3, 0, 0, nd, nb);
    chk("t4 done cycle", nd, 66);
    chk("t4 pass", pass_a, 1);
    mode_a = 0; inj_a = 0; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    repeat (9) @(posedge clk);
    #1;
    mode_a = 2; inj_a = 1; ia_a = 3; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    chk("t5 done pulses", cnt, 1);
    chk("t5 pass", pass_a, 1);
    chk("t5 err", err_a, 0);
    mode_a = 0; inj_a = 0; start_a = 1;
    d1 = 0;
    d2 = 0;
    for (int n = 1; n <= 300 && d2 == 0; n++) begin
      @(negedge clk);
      if (done_a) begin
        if (d1 == 0) d1 = n;
        else d2 = n;
      end
    end
    start_a = 0;
    chk("t6 retrigger gap", d2 - d1, 67);
    chk("t6 pass", pass_a, 1);
    repeat (80) @(posedge clk);
    #1;
    chk("t6 idle", busy_a, 0);
    run(1, 2'd0, 0, 0, nd, nb);
    chk("b1 done cycle", nd, 42);
    chk("b1 busy cycles", nb, 41);
    chk("b1 pass", pass_b, 1);
    chk("b1 err", err_b, 0);
    for (int a = 0; a < DB; a++) chk("b1 mem", dut_b.u_ram.mem[a], 64'(a % 16));
    run(1, 2'd0, 1, 25, nd, nb);
    chk("b2 pass", pass_b, 1);
    chk("b2 err", err_b, 0);
    run(1, 2'd0, 1, 19, nd, nb);
    chk("b3 pass", pass_b, 0);
    chk("b3 err", err_b, 1);
    chk("b3 fa", fa_b, 19);
    chk("b3 fd", fd_b, 4'h2);
    run(1, 2'd2, 0, 0, nd, nb);
    chk("b4 pass", pass_b, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
